ripple_carry_adder: RTL and testbench
=====================================

Name: ripple_carry_adder

Overview:
- Parameterised N-bit binary adder built as a ripple chain of 1-bit full adders: op = A + B + c_in, carry-out on c_op.
- Sum and carry are registered, giving one clock of latency with a valid flag.
- Leaf arithmetic block for datapaths that need a small, area-cheap adder where ripple delay is acceptable.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1 to 64).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry into bit 0.
- in_valid  input  1  operands and c_in valid this cycle.
- op  output  WIDTH  registered sum bits [WIDTH-1:0].
- c_op  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  op/c_op hold a freshly computed result.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Combinational core:
  - Carry chain c[0] = c_in.
  - For each bit i: s[i] = A[i]^B[i]^c[i] and c[i+1] = (A[i]&B[i]) | (c[i]&(A[i]^B[i])).
  - Result is {c[WIDTH], s} = A + B + c_in, exact. No truncation and no overflow loss: the full WIDTH+1-bit result is always represented.
- Register stage (rising edge of clk):
  - rst=1: op <= 0, c_op <= 0, out_valid <= 0. Reset has priority over in_valid.
  - rst=0, in_valid=1: op <= s, c_op <= c[WIDTH], out_valid <= 1.
  - rst=0, in_valid=0: op and c_op hold their previous values, out_valid <= 0.
- Latency: exactly 1 cycle from in_valid sampled high to out_valid high with the matching result.
- Throughput: one result per cycle. Back-to-back in_valid produces back-to-back out_valid.
- No backpressure; the consumer must accept out_valid when asserted.
- Reset mid-operation: a valid input sampled in the same cycle as rst=1 is discarded. The first post-reset result appears one cycle after the first in_valid with rst=0.
- Boundary cases:
  - All-ones + all-ones + 1 gives op = all-ones, c_op = 1.
  - 0 + 0 + 0 gives op = 0, c_op = 0.
  - All-ones + 0 + 1 ripples the carry through every bit, giving op = 0, c_op = 1.
- Inputs X/Z are not filtered. Outputs reflect inputs only when in_valid=1.
- No latches; the core is purely combinational, and the only state is op, c_op, out_valid.

Decomposition:
- Shared package rca_pkg:
  - Constant RCA_DEFAULT_WIDTH = 4.
  - Typedef for the {carry, sum} result struct, used by this block's output assembly and by benches.
- One sub-module: full_adder (inputs a, b, cin; outputs s, cout), instantiated WIDTH times via generate loop.
- Top-level ripple_carry_adder holds the generate chain and the output register.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, A=4'hF, B=4'hF → op=0, c_op=0, out_valid=0 throughout. Deassert rst → first result one cycle after the next sampled in_valid.
- Basic adds, WIDTH=4, back-to-back in_valid:
  - A=5, B=5, c_in=0 → op=4'hA, c_op=0.
  - A=3, B=5, c_in=1 → op=4'h9, c_op=0.
  - A=5, B=7, c_in=0 → op=4'hC, c_op=0.
  - A=3, B=7, c_in=1 → op=4'hB, c_op=0.
  - Each result appears one cycle after its inputs, with out_valid high every cycle.
- Carry-out and full ripple:
  - A=4'hF, B=4'hF, c_in=1 → op=4'hF, c_op=1.
  - A=4'hF, B=0, c_in=1 → op=4'h0, c_op=1.
  - A=8, B=8, c_in=0 → op=0, c_op=1.
- Hold: drive A=2, B=3, c_in=0 valid, then in_valid=0 for 3 cycles with changing A/B → op stays 4'h5, c_op=0, out_valid high once then low.
- Reset mid-stream: in_valid=1 with A=9, B=9 in the same cycle as rst=1 → no out_valid, op=0, c_op=0. The next valid input A=1, B=1, c_in=1 gives op=3.
- Exhaustive (WIDTH=4): all 512 combinations of A, B, c_in against a reference model → {c_op, op} == A+B+c_in for each. Repeat a random sweep at WIDTH=16.

Source files
------------

// File: rtl/rca_pkg.sv
// ---------------------------------------------------------------------------
// rca_pkg
// Shared constants and types for the ripple-carry adder block and its benches.
//   RCA_DEFAULT_WIDTH : default operand width
//   RCA_MAX_WIDTH     : widest supported operand (sizes the result struct)
//   rca_result_t      : {carry, sum} result record, sum zero-extended to
//                       RCA_MAX_WIDTH so one type serves every WIDTH
// ---------------------------------------------------------------------------
package rca_pkg;

    localparam int RCA_DEFAULT_WIDTH = 4;
    localparam int RCA_MAX_WIDTH     = 64;

    typedef struct packed {
        logic                     carry;
        logic [RCA_MAX_WIDTH-1:0] sum;
    } rca_result_t;

endpackage : rca_pkg

// File: rtl/ripple_carry_adder_if.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder_if
// Operand/result bundle for ripple_carry_adder.
//   A, B      : unsigned operands (WIDTH bits)
//   c_in      : carry into bit 0
//   in_valid  : A/B/c_in are valid this cycle
//   op        : registered sum
//   c_op      : registered carry out of the top bit
//   out_valid : op/c_op hold a result computed from the previous cycle's inputs
//
// Handshake: valid-only, no ready. The producer asserts in_valid for one
// cycle per operand set; the block always accepts it. out_valid pulses one
// cycle later and the consumer must take the result in that cycle, as there
// is no backpressure path.
// ---------------------------------------------------------------------------
interface ripple_carry_adder_if
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             c_in;
    logic             in_valid;
    logic [WIDTH-1:0] op;
    logic             c_op;
    logic             out_valid;

    // Producer side (bench / upstream datapath).
    modport master (
        output A, B, c_in, in_valid,
        input  op, c_op, out_valid
    );

    // Adder side.
    modport slave (
        input  A, B, c_in, in_valid,
        output op, c_op, out_valid
    );

endinterface : ripple_carry_adder_if

// File: rtl/ripple_carry_adder_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit full adder cell, the link of the ripple chain.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term is shared by sum and carry.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder
// WIDTH-bit unsigned adder built from a chain of full_adder cells, with a
// single output register stage: {c_op, op} = A + B + c_in, one cycle later.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears op/c_op/out_valid
//   bus : ripple_carry_adder_if.slave (A, B, c_in, in_valid -> op, c_op, out_valid)
// op/c_op hold their last value when in_valid is low; out_valid drops.
// ---------------------------------------------------------------------------
module ripple_carry_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    ripple_carry_adder_if.slave bus
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    rca_result_t      res;
    logic             res_unused;

    // Carry chain: c[i] feeds cell i, cell i drives c[i+1].
    assign c[0] = bus.c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (bus.A[i]),
            .b    (bus.B[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    // Assemble the full WIDTH+1-bit result; sum is zero-extended to the
    // package-wide width so the same struct type works for every WIDTH.
    always_comb begin
        res              = '0;
        res.carry        = c[WIDTH];
        res.sum[WIDTH-1:0] = s;
    end

    // Bits above WIDTH are constant zero and intentionally not consumed.
    assign res_unused = ^res.sum;

    // Output register. Reset wins over in_valid, so an operand set
    // presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.op        <= '0;
            bus.c_op      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            bus.op        <= res.sum[WIDTH-1:0];
            bus.c_op      <= res.carry;
            bus.out_valid <= 1'b1;
        end else begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// ---------------------------------------------------------------------------
// tb_ripple_carry_adder
// Bench for ripple_carry_adder at WIDTH=4 (directed table, hold, reset and
// exhaustive sweep) and WIDTH=16 (corner cases plus a random sweep).
// ---------------------------------------------------------------------------
module tb_ripple_carry_adder;
    import rca_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    ripple_carry_adder_if #(.WIDTH(4))  bus4 ();
    ripple_carry_adder_if #(.WIDTH(16)) bus16 ();

    ripple_carry_adder #(.WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    ripple_carry_adder #(.WIDTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    // ---------------- bookkeeping ----------------
    int n_checks;
    int n_fail;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_op;
        logic       exp_c;
    } vec_t;

    vec_t vecs [7];

    // ---------------- driver tasks ----------------
    task automatic drive4(input logic [3:0] a, input logic [3:0] b,
                          input logic cin, input logic v);
        bus4.A        = a;
        bus4.B        = b;
        bus4.c_in     = cin;
        bus4.in_valid = v;
    endtask

    task automatic drive16(input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic v);
        bus16.A        = a;
        bus16.B        = b;
        bus16.c_in     = cin;
        bus16.in_valid = v;
    endtask

    // Advance one edge and settle; outputs then reflect the inputs driven
    // before the call.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checkers ----------------
    task automatic check4(input string name, input logic [3:0] exp_op,
                          input logic exp_c, input logic exp_v);
        n_checks++;
        if (bus4.op !== exp_op || bus4.c_op !== exp_c || bus4.out_valid !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got op=%h c_op=%b out_valid=%b, expected op=%h c_op=%b out_valid=%b",
                     name, bus4.op, bus4.c_op, bus4.out_valid, exp_op, exp_c, exp_v);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] exp_op,
                           input logic exp_c, input logic exp_v);
        n_checks++;
        if (bus16.op !== exp_op || bus16.c_op !== exp_c || bus16.out_valid !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got op=%h c_op=%b out_valid=%b, expected op=%h c_op=%b out_valid=%b",
                     name, bus16.op, bus16.c_op, bus16.out_valid, exp_op, exp_c, exp_v);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [4:0]  ref4;
        logic [16:0] ref16;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{a: 4'h5, b: 4'h5, cin: 1'b0, exp_op: 4'hA, exp_c: 1'b0};
        vecs[1] = '{a: 4'h3, b: 4'h5, cin: 1'b1, exp_op: 4'h9, exp_c: 1'b0};
        vecs[2] = '{a: 4'h5, b: 4'h7, cin: 1'b0, exp_op: 4'hC, exp_c: 1'b0};
        vecs[3] = '{a: 4'h3, b: 4'h7, cin: 1'b1, exp_op: 4'hB, exp_c: 1'b0};
        vecs[4] = '{a: 4'hF, b: 4'hF, cin: 1'b1, exp_op: 4'hF, exp_c: 1'b1};
        vecs[5] = '{a: 4'hF, b: 4'h0, cin: 1'b1, exp_op: 4'h0, exp_c: 1'b1};
        vecs[6] = '{a: 4'h8, b: 4'h8, cin: 1'b0, exp_op: 4'h0, exp_c: 1'b1};

        // Reset held two cycles with a valid all-ones operand set present.
        rst = 1'b1;
        drive4(4'hF, 4'hF, 1'b0, 1'b1);
        drive16(16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        check4("reset_cycle1", 4'h0, 1'b0, 1'b0);
        tick();
        check4("reset_cycle2", 4'h0, 1'b0, 1'b0);
        check16("reset16", 16'h0, 1'b0, 1'b0);

        // Out of reset, idle: nothing produced until in_valid is sampled.
        rst = 1'b0;
        drive4(4'h0, 4'h0, 1'b0, 1'b0);
        tick();
        check4("post_reset_idle", 4'h0, 1'b0, 1'b0);

        // Directed table, back-to-back.
        for (int i = 0; i < 7; i++) begin
            drive4(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
            tick();
            check4($sformatf("vec%0d", i), vecs[i].exp_op, vecs[i].exp_c, 1'b1);
        end

        // Hold: one valid, then three idle cycles with changing operands.
        drive4(4'h2, 4'h3, 1'b0, 1'b1);
        tick();
        check4("hold_load", 4'h5, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 1'b0);
            tick();
            check4($sformatf("hold%0d", i), 4'h5, 1'b0, 1'b0);
        end

        // Reset arriving with a valid operand set drops it.
        rst = 1'b1;
        drive4(4'h9, 4'h9, 1'b0, 1'b1);
        tick();
        check4("reset_midstream", 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        drive4(4'h1, 4'h1, 1'b1, 1'b1);
        tick();
        check4("after_reset_first", 4'h3, 1'b0, 1'b1);

        // Exhaustive sweep at WIDTH=4 against integer arithmetic.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    ref4 = 5'(a) + 5'(b) + 5'(ci);
                    drive4(4'(a), 4'(b), 1'(ci), 1'b1);
                    tick();
                    check4($sformatf("exh_%0d_%0d_%0d", a, b, ci), ref4[3:0], ref4[4], 1'b1);
                end
            end
        end
        drive4(4'h0, 4'h0, 1'b0, 1'b0);

        // WIDTH=16 corners.
        drive16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        tick();
        check16("w16_ones_ones_1", 16'hFFFF, 1'b1, 1'b1);
        drive16(16'hFFFF, 16'h0000, 1'b1, 1'b1);
        tick();
        check16("w16_full_ripple", 16'h0000, 1'b1, 1'b1);
        drive16(16'h0000, 16'h0000, 1'b0, 1'b1);
        tick();
        check16("w16_zero", 16'h0000, 1'b0, 1'b1);

        // WIDTH=16 random sweep.
        for (int i = 0; i < 200; i++) begin
            ra    = 16'($urandom_range(0, 65535));
            rb    = 16'($urandom_range(0, 65535));
            rc    = 1'($urandom_range(0, 1));
            ref16 = 17'(ra) + 17'(rb) + 17'(rc);
            drive16(ra, rb, rc, 1'b1);
            tick();
            check16($sformatf("w16_rand%0d", i), ref16[15:0], ref16[16], 1'b1);
        end
        drive16(16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        check16("w16_idle_hold", ref16[15:0], ref16[16], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ripple_carry_adder
